branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Parametrised dynamic branch predictor for the pipelined RV32 core; replaces the fixed
//  "predict not-taken, flush on mispredict" fetch policy. Fetch presents the PC and receives a
//  same-cycle taken guess plus the table index used; EX returns that index with the resolved
//  outcome. Modes: bimodal (GHR_BITS=0) or gshare (GHR_BITS>0). Also keeps performance counters.
// PARAMETERS
//  PC_WIDTH    32  width of the fetch PC
//  ENTRIES     64  counter-table depth; power of 2, >=2; IDX_BITS = log2(ENTRIES)
//  CNT_BITS    2   saturating-counter width, 1..4
//  GHR_BITS    0   global-history length; 0 = bimodal; must be <= IDX_BITS
//  STAT_WIDTH  32  width of each performance counter
// PORTS
//  clk           in   1          core clock; all state updates on posedge
//  rst           in   1          asynchronous, active-low reset (state cleared while rst==0)
//  pred_en       in   1          1 = use table; 0 = guess_taken forced 0 (training continues)
//  guess_valid   in   1          fetch lookup this cycle (counted in stat_lookups)
//  guess_pc      in   PC_WIDTH   PC being fetched
//  guess_taken   out  1          predicted direction (combinational)
//  guess_idx     out  IDX_BITS   table index used; carried down the pipe to EX
//  upd_valid     in   1          resolved conditional branch in EX this cycle
//  upd_idx       in   IDX_BITS   guess_idx captured at fetch of that branch
//  upd_taken     in   1          actual outcome
//  upd_mispred   in   1          guess differed from outcome (statistics only)
//  stat_clear    in   1          synchronous clear of both statistics counters
//  stat_lookups  out  STAT_WIDTH count of guess_valid cycles
//  stat_mispred  out  STAT_WIDTH count of upd_valid && upd_mispred cycles
// BEHAVIOUR
//  - Reset (rst==0, async): every counter = 2^(CNT_BITS-1)-1 (weakly not-taken), GHR = 0,
//    stats = 0. Hence guess_taken = 0, guess_idx = guess_pc[IDX_BITS+1:2] during/after reset.
//  - Index: guess_idx = guess_pc[IDX_BITS+1:2] XOR {zero-extended GHR}; PC[1:0] ignored;
//    PCs differing only above bit IDX_BITS+1 alias to the same entry (no tags).
//  - Prediction: guess_taken = pred_en & MSB(counter[guess_idx]); zero latency; valid whenever
//    guess_pc is stable; guess_valid affects only statistics.
//  - Update (posedge, upd_valid=1): counter[upd_idx] += 1 if upd_taken, -= 1 otherwise;
//    saturates at 2^CNT_BITS-1 and 0, never wraps. No update when upd_valid=0.
//  - GHR (GHR_BITS>0): on upd_valid, GHR <= {GHR[GHR_BITS-2:0], upd_taken}; updated only at
//    resolution (non-speculative); flushed wrong-path fetches never touch it.
//  - Same-cycle lookup and update of one entry: lookup returns the pre-update value
//    (read-before-write); the new value is visible from the next cycle. The lookup index
//    uses the pre-update GHR.
//  - Stats: saturating increment, stop at all-ones. stat_clear has priority over an increment
//    in the same cycle (result 0).
//  - Async reset mid-operation: all state clears immediately; an in-flight update in that
//    cycle is dropped.
// TESTING
//  (ENTRIES=64, CNT_BITS=2, GHR_BITS=0 unless stated)
//  1. Reset, pred_en=1, guess_pc=0x4000_0010 -> guess_idx=4, guess_taken=0.
//  2. upd idx 4 taken x3 -> counter 1->2->3->3; guess_taken=1 after 1st edge; saturates at 3.
//     guess_pc=0x4000_0110 (aliases idx 4) also -> guess_taken=1.
//  3. From counter 3, upd idx 4 not-taken x4 -> 2,1,0,0; guess_taken 1,0,0,0; no wrap.
//  4. Counter 1, same cycle guess_pc idx 4 + upd idx 4 taken -> guess_taken=0 that cycle,
//     1 next cycle. pred_en=0 -> guess_taken=0 while counter still trains.
//  5. GHR_BITS=4: two taken updates to idx 9 -> GHR=4'b0011; guess_pc=0x4000_0010 ->
//     guess_idx=7.
//  6. 10 guess_valid cycles + 3 mispred updates -> stats 10/3; stat_clear with simultaneous
//     increment -> 0/0; rst=0 mid-run -> counters=1, stats=0 before next clk edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: bimodal (GHR_BITS=0) or gshare saturating-counter table
// with same-cycle lookup, resolution-time training and saturating performance counters.
module branch_predictor #(
  parameter  int unsigned PC_WIDTH   = 32,
  parameter  int unsigned ENTRIES    = 64,
  parameter  int unsigned CNT_BITS   = 2,
  parameter  int unsigned GHR_BITS   = 0,
  parameter  int unsigned STAT_WIDTH = 32,
  localparam int unsigned IDX_BITS   = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_en,
  input  logic                  guess_valid,
  input  logic [PC_WIDTH-1:0]   guess_pc,
  output logic                  guess_taken,
  output logic [IDX_BITS-1:0]   guess_idx,
  input  logic                  upd_valid,
  input  logic [IDX_BITS-1:0]   upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_mispred,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_lookups,
  output logic [STAT_WIDTH-1:0] stat_mispred
);

  localparam int unsigned           GHR_W     = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CNT_BITS-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_BITS-1:0]   CNT_INIT  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX  = '1;

  logic [CNT_BITS-1:0]   cnt_q [ENTRIES];
  logic [CNT_BITS-1:0]   cnt_d [ENTRIES];
  logic [GHR_W-1:0]      ghr_q, ghr_d;
  logic [STAT_WIDTH-1:0] lookups_q, lookups_d;
  logic [STAT_WIDTH-1:0] mispred_q, mispred_d;
  logic [IDX_BITS-1:0]   hist_idx;
  logic                  unused_pc;

  // Only the word-index bits of the PC select an entry; the rest alias freely.
  assign unused_pc = ^{guess_pc[PC_WIDTH-1:IDX_BITS+2], guess_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not yet visible.
  always_comb begin
    hist_idx = '0;
    if (GHR_BITS > 0) hist_idx = IDX_BITS'(ghr_q);
    guess_idx   = guess_pc[IDX_BITS+1:2] ^ hist_idx;
    guess_taken = pred_en & cnt_q[guess_idx][CNT_BITS-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    ghr_d = ghr_q;
    if (upd_valid) begin
      if (upd_taken && (cnt_q[upd_idx] != CNT_MAX)) begin
        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_BITS'(1);
      end else if (!upd_taken && (cnt_q[upd_idx] != '0)) begin
        cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_BITS'(1);
      end
      if (GHR_BITS > 0) ghr_d = GHR_W'({ghr_q, upd_taken});
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    lookups_d = lookups_q;
    mispred_d = mispred_q;
    if (stat_clear) begin
      lookups_d = '0;
      mispred_d = '0;
    end else begin
      if (guess_valid && (lookups_q != STAT_MAX)) lookups_d = lookups_q + STAT_WIDTH'(1);
      if (upd_valid && upd_mispred && (mispred_q != STAT_MAX)) begin
        mispred_d = mispred_q + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= CNT_INIT;
      ghr_q     <= '0;
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ghr_q     <= ghr_d;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_mispred = mispred_q;

endmodule
